// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding and the oversampling ratio.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_W     = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA_SEND,
    PARITY,
    STOP
  } uart_state_e;

  // True on the baud tick that closes the current bit period.
  function automatic logic last_tick(
    input logic              tick_en,
    input logic [TICK_W-1:0] cnt
  );
    return tick_en && (cnt == TICK_W'(OVERSAMPLE - 1));
  endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter, 16x oversampled bit timing, LSB-first data.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baudTick,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  tx_start,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  tx_done
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  assign tx_ready = (state_q == IDLE);
  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign accept   = tx_start && tx_ready;
  assign bit_end  = last_tick(baudTick, tick_q);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // Bit timing only advances on baud ticks; everything holds otherwise.
    if (state_q != IDLE && baudTick) begin
      tick_d = tick_q + TICK_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d = START;
          tick_d  = '0;
          bit_d   = '0;
          shift_d = dataIn;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^dataIn;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA_SEND;
          tick_d  = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA_SEND: begin
        if (bit_end) begin
          tick_d = '0;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tick_d  = '0;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tick_d  = '0;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter.
// Compares the line, sampled once per baud tick, against a per-tick frame model.
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME_TICKS = (2 + DW + P) * 16;
  localparam int BUDGET      = 4000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          baudTick = 1'b0;
  logic          tx_start = 1'b0;
  logic [DW-1:0] dataIn = '0;
  logic          tx_ready, tx, tx_done;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   bt_per  = 4;
  logic bt_en   = 1'b1;
  int   bt_cnt  = 0;

  logic cap_q[$];
  logic exp_q[$];
  int   cap_done, cap_glitch, cap_ready_bad, cap_cycles;
  logic cap_first, cap_to;

  uart_transmitter #(.DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .baudTick (baudTick),
    .dataIn   (dataIn),
    .tx_start (tx_start),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bt_cnt >= bt_per - 1) bt_cnt <= 0;
    else bt_cnt <= bt_cnt + 1;
    baudTick <= bt_en && (bt_cnt >= bt_per - 1);
  end

  // Line level expected at every baud tick of one frame.
  function automatic void build_model(input logic [DW-1:0] d);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(1'b0);
    for (int b = 0; b < DW; b++)
      for (int i = 0; i < 16; i++) exp_q.push_back(d[b]);
`ifdef UART_TX_PARITY_EN
    for (int i = 0; i < 16; i++) exp_q.push_back(^d);
`endif
    for (int i = 0; i < 16; i++) exp_q.push_back(1'b1);
  endfunction

  function automatic int first_diff();
    int n;
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (cap_q[i] !== exp_q[i]) return i;
    if (cap_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic issue(input logic [DW-1:0] d, input bit hold);
    int w;
    w = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && w < BUDGET) begin
      @(negedge clk);
      w++;
    end
    if (tx_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_wait: tx_ready=%b after %0d cycles, required 1",
               tx_ready, w);
    end
    dataIn   = d;
    tx_start = 1'b1;
    @(negedge clk);
    if (!hold) tx_start = 1'b0;
  endtask

  // Called on the first negedge after acceptance; returns on the tx_done cycle.
  task automatic capture();
    logic prev_tx, prev_bt;
    cap_q.delete();
    cap_done = 0; cap_glitch = 0; cap_ready_bad = 0; cap_cycles = 0;
    cap_to = 1'b1;
    cap_first = tx;
    prev_tx = tx;
    prev_bt = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      if (c > 0 && tx !== prev_tx && !prev_bt) cap_glitch++;
      if (tx_done === 1'b1) begin
        cap_done++;
        cap_to = 1'b0;
        break;
      end
      if (tx_ready !== 1'b0) cap_ready_bad++;
      if (baudTick) cap_q.push_back(tx);
      prev_tx = tx;
      prev_bt = baudTick;
      cap_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (tx !== 1'b1) begin
      n_fail++; $display("FAIL reset_tx: got %b, required 1", tx);
    end
    n_tests++;
    if (tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b, required 1", tx_ready);
    end
    n_tests++;
    if (tx_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b, required 0", tx_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_a5();
    int d;
    bt_per = 4;
    build_model(8'hA5);
    issue(8'hA5, 1'b0);
    capture();
    n_tests++;
    if (cap_first !== 1'b0 || cap_ready_bad != 0) begin
      n_fail++;
      $display("FAIL a5_start: tx=%b ready_high_cycles=%0d, required tx=0 ready_high=0",
               cap_first, cap_ready_bad);
    end
    d = first_diff();
    n_tests++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL a5_bits: first diff at tick %0d, got %0d ticks, required %0d",
               d, cap_q.size(), exp_q.size());
    end
    n_tests++;
    if (cap_done != 1 || tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL a5_done: done=%0d ready=%b, required done=1 ready=1",
               cap_done, tx_ready);
    end
    n_tests++;
    if (cap_cycles < 4 * FRAME_TICKS - 3 || cap_cycles > 4 * FRAME_TICKS) begin
      n_fail++;
      $display("FAIL a5_cycles: got %0d clk, required %0d..%0d",
               cap_cycles, 4 * FRAME_TICKS - 3, 4 * FRAME_TICKS);
    end
    n_tests++;
    if (cap_glitch != 0) begin
      n_fail++; $display("FAIL a5_glitch: got %0d off-tick changes, required 0", cap_glitch);
    end
    @(negedge clk);
    n_tests++;
    if (tx_done !== 1'b0 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL a5_pulse: done=%b tx=%b, required done=0 tx=1", tx_done, tx);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    build_model(8'h00);
    issue(8'h00, 1'b1);
    fork
      capture();
      begin
        repeat (100) @(negedge clk);
        dataIn = 8'h5A;
      end
    join
    d = first_diff();
    n_tests++;
    if (d != -1 || cap_done != 1) begin
      n_fail++;
      $display("FAIL b2b_first: diff at %0d done=%0d, required diff=-1 done=1", d, cap_done);
    end
    n_tests++;
    if (tx !== 1'b1 || tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap: tx=%b ready=%b, required 1 1", tx, tx_ready);
    end
    dataIn = 8'hFF;
    @(negedge clk);
    tx_start = 1'b0;
    build_model(8'hFF);
    capture();
    n_tests++;
    if (cap_first !== 1'b0) begin
      n_fail++; $display("FAIL b2b_restart: tx=%b one cycle after idle, required 0", cap_first);
    end
    d = first_diff();
    n_tests++;
    if (d != -1 || cap_done != 1) begin
      n_fail++;
      $display("FAIL b2b_second: diff at %0d done=%0d, required diff=-1 done=1", d, cap_done);
    end
  endtask

  task automatic test_ignore_midframe();
    logic [DW-1:0] v;
    int d, viol;
    v = DW'($urandom);
    build_model(v);
    issue(v, 1'b0);
    fork
      capture();
      begin
        repeat (200) @(negedge clk);
        dataIn   = 8'h3C;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    d = first_diff();
    n_tests++;
    if (d != -1 || cap_done != 1) begin
      n_fail++;
      $display("FAIL ignore_frame: diff at %0d done=%0d, required diff=-1 done=1", d, cap_done);
    end
    viol = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0) viol++;
    end
    n_tests++;
    if (viol != 0) begin
      n_fail++; $display("FAIL ignore_extra: got %0d busy cycles after frame, required 0", viol);
    end
  endtask

  task automatic test_reset_midframe();
    logic [DW-1:0] v;
    int ticks, viol, d;
    v = DW'($urandom);
    issue(v, 1'b0);
    ticks = 0;
    for (int c = 0; c < BUDGET && ticks < 70; c++) begin
      if (baudTick) ticks++;
      @(negedge clk);
    end
    n_tests++;
    if (tx !== v[3]) begin
      n_fail++; $display("FAIL rst_bit3: tx=%b, required %b", tx, v[3]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abort: tx=%b ready=%b done=%b, required 1 1 0", tx, tx_ready, tx_done);
    end
    viol = 0;
    repeat (120) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx !== 1'b1) viol++;
    end
    n_tests++;
    if (viol != 0) begin
      n_fail++; $display("FAIL rst_quiet: got %0d active cycles, required 0", viol);
    end
    build_model(8'h81);
    issue(8'h81, 1'b0);
    capture();
    d = first_diff();
    n_tests++;
    if (d != -1 || cap_done != 1) begin
      n_fail++;
      $display("FAIL rst_next81: diff at %0d done=%0d, required diff=-1 done=1", d, cap_done);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    rst = 1'b1; tx_start = 1'b1; dataIn = 8'h55;
    @(negedge clk);
    rst = 1'b0; tx_start = 1'b0;
    n_tests++;
    if (tx_ready !== 1'b1 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_prio: ready=%b tx=%b, required 1 1", tx_ready, tx);
    end
  endtask

  task automatic test_freeze();
    logic [DW-1:0] v;
    logic frozen;
    int viol, d;
    v = DW'($urandom);
    build_model(v);
    viol = 0;
    issue(v, 1'b0);
    fork
      capture();
      begin
        repeat (150) @(negedge clk);
        bt_en = 1'b0;
        repeat (2) @(negedge clk);
        frozen = tx;
        repeat (100) begin
          @(negedge clk);
          if (tx !== frozen || tx_done !== 1'b0) viol++;
        end
        bt_en = 1'b1;
      end
    join
    n_tests++;
    if (viol != 0 || cap_glitch != 0) begin
      n_fail++;
      $display("FAIL freeze_hold: got %0d changes, %0d off-tick, required 0 0", viol, cap_glitch);
    end
    d = first_diff();
    n_tests++;
    if (d != -1 || cap_done != 1) begin
      n_fail++;
      $display("FAIL freeze_frame: diff at %0d ticks=%0d done=%0d, required -1 %0d 1",
               d, cap_q.size(), cap_done, FRAME_TICKS);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] v;
    int d;
    for (int k = 0; k < 6; k++) begin
      bt_per = $urandom_range(1, 5);
      v = DW'($urandom);
      build_model(v);
      repeat ($urandom_range(0, 10)) @(negedge clk);
      issue(v, 1'b0);
      capture();
      d = first_diff();
      n_tests++;
      if (d != -1 || cap_done != 1 || cap_glitch != 0 || cap_ready_bad != 0) begin
        n_fail++;
        $display("FAIL rand_%0d: data=%h per=%0d diff=%0d done=%0d glitch=%0d, required -1 1 0",
                 k, v, bt_per, d, cap_done, cap_glitch);
      end
    end
    bt_per = 4;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [DW-1:0] vals [2];
    logic          want [2];
    logic          got;
    int            idx;
    vals[0] = 8'h07; want[0] = 1'b1;
    vals[1] = 8'h03; want[1] = 1'b0;
    idx = (1 + DW) * 16 + 8;
    bt_per = 2;
    for (int k = 0; k < 2; k++) begin
      build_model(vals[k]);
      issue(vals[k], 1'b0);
      capture();
      got = (cap_q.size() > idx) ? cap_q[idx] : 1'bx;
      n_tests++;
      if (got !== want[k] || cap_q.size() != 176) begin
        n_fail++;
        $display("FAIL parity_%h: bit=%b ticks=%0d, required %b 176",
                 vals[k], got, cap_q.size(), want[k]);
      end
    end
    bt_per = 4;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_a5();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    test_reset_priority();
    test_freeze();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving data bits per frame (min 5, max 16).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port baudTick  input  1  one-cycle enable at 16x the baud rate.
REQ-005 SHALL have port dataIn  input  DATA_WIDTH  byte to send, sampled only at acceptance.
REQ-006 SHALL have port tx_start  input  1  request to send dataIn.
REQ-007 SHALL have port tx_ready  output  1  high when idle and able to accept.
REQ-008 SHALL have port tx  output  1  serial line, idle-high, registered output.
REQ-009 SHALL have port tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-010 SHALL implement states idle, start, data_send, parity (macro only) and stop.
REQ-011 SHALL accept a frame on a posedge where tx_start=1 and tx_ready=1, latching dataIn into a shift register and entering start.
REQ-012 SHALL ignore tx_start while tx_ready=0; no queuing, no effect on the current frame.
REQ-013 SHALL drive tx=0 from the cycle after acceptance and tx_ready=0 from the same cycle.
REQ-014 SHALL hold each bit for exactly 16 baudTick pulses, using a 4-bit tick counter cleared on every bit boundary.
REQ-015 SHALL advance to the next bit on the cycle where baudTick=1 and tick counter=15.
REQ-016 SHALL send data bits LSB first, using a counter of width $clog2(DATA_WIDTH) that wraps only at the end of the frame.
REQ-017 SHALL enter stop after bit DATA_WIDTH-1, or after parity when it is compiled in, and drive tx=1 for 16 ticks.
REQ-018 SHALL return to idle on the 16th stop tick, raise tx_done for that single cycle, and raise tx_ready on the next cycle.
REQ-019 SHALL freeze all counters and tx while baudTick=0, with no timeout.
REQ-020 SHALL accept a new tx_start on the first idle cycle, giving back-to-back frames separated by exactly one clk cycle of tx=1 beyond stop.
REQ-021 SHALL send the frame captured at acceptance even if dataIn changes mid-frame.
REQ-022 SHALL give a frame length of (2+DATA_WIDTH+P)*16 baudTicks, where P=1 with parity and 0 without.

Reset
REQ-023 SHALL, while rst=1, force state=idle, tick/bit counters=0, shift register=0, tx=1, tx_ready=1 and tx_done=0 on the next posedge.
REQ-024 SHALL abort a frame if reset occurs mid-frame, with tx returning high on the next posedge and no tx_done pulse.
REQ-025 SHALL give rst priority over a simultaneous tx_start; no frame is accepted.

Configuration
REQ-026 SHALL, when macro UART_TX_PARITY_EN is defined, insert a parity state after the data bits that sends the even-parity bit (XOR of the latched data) for 16 ticks.
REQ-027 SHALL, without UART_TX_PARITY_EN, omit the parity state and parity logic, going directly from data_send to stop.

Structure
REQ-028 SHALL take the state enum typedef and constant OVERSAMPLE=16 from shared package uart_pkg, which the receiver also uses.
REQ-029 SHALL be a single flat module with no sub-module.

Verification
REQ-030 SHALL cover: DATA_WIDTH=8, baudTick every 4 clk, send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 64 clk; tx_done pulses once.
REQ-031 SHALL cover: tx_start held high for two frames 0x00 then 0xFF -> two complete frames with one idle cycle between; second frame data equals dataIn at second acceptance.
REQ-032 SHALL cover: tx_start pulsed mid-frame with 0x3C -> ignored; current frame unchanged; no extra frame.
REQ-033 SHALL cover: rst asserted at data bit 3 -> tx=1, tx_ready=1 next cycle; no tx_done; next frame 0x81 correct.
REQ-034 SHALL cover: UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame 176 ticks.
REQ-035 SHALL cover: baudTick held low for 100 clk mid-bit -> tx and counters frozen; frame resumes with total tick count unchanged.
